// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS PWM output stage.
package dds_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam int         DEF_DATA_W   = 8;
  localparam int         MID_SCALE    = 1 << (DEF_DATA_W - 1);
  localparam logic [7:0] UNDERRUN_MAX = 8'd255;
endpackage

// File: rtl/pwm_frame_counter.sv
// Free-running PWM frame counter; held at zero while not running.
module pwm_frame_counter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [DATA_W-1:0] cnt,
  output logic              wrap,
  output logic              frame_zero
);
  logic [DATA_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = run ? cnt_q + DATA_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt        = cnt_q;
  assign wrap       = run & (cnt_q == '1);
  assign frame_zero = (cnt_q == '0);
endmodule

// File: rtl/dds_pwm_dac.sv
// Double-buffered signed-sample to PWM converter with underrun reporting
// and a drain-to-idle sequence when disabled.
module dds_pwm_dac
  import dds_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              pwm_out,
  output logic              frame_start,
  output logic              underrun,
  output logic [7:0]        underrun_count
);
  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              shadow_full_q, shadow_full_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic              underrun_q, underrun_d;
  logic [7:0]        ucnt_q, ucnt_d;

  logic [DATA_W-1:0] cnt;
  logic              wrap, frame_zero, running, accept;

  assign running = (state_q != IDLE);
  assign accept  = s_valid & ~shadow_full_q;

  pwm_frame_counter #(.DATA_W(DATA_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .run        (running),
    .cnt        (cnt),
    .wrap       (wrap),
    .frame_zero (frame_zero)
  );

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    active_d      = active_q;
    underrun_d    = 1'b0;
    ucnt_d        = ucnt_q;

    // Shadow holds the already offset-converted duty.
    if (accept) begin
      shadow_d      = s_data ^ MSB_MASK;
      shadow_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (en && shadow_full_q) begin
          state_d       = RUN;
          active_d      = shadow_q;
          shadow_full_d = 1'b0;
        end
      end
      RUN: begin
        if (wrap) begin
          if (shadow_full_q) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
          end else begin
            underrun_d = 1'b1;
            if (ucnt_q != UNDERRUN_MAX) ucnt_d = ucnt_q + 8'd1;
          end
        end
        if (!en) state_d = DRAIN;
      end
      DRAIN: begin
        if (en)        state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      active_q      <= MSB_MASK;
      underrun_q    <= 1'b0;
      ucnt_q        <= 8'd0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      active_q      <= active_d;
      underrun_q    <= underrun_d;
      ucnt_q        <= ucnt_d;
    end
  end

  assign s_ready        = ~shadow_full_q;
  assign pwm_out        = running & (cnt < active_q);
  assign frame_start    = running & frame_zero;
  assign underrun       = underrun_q;
  assign underrun_count = ucnt_q;
endmodule

// File: doc/dds_pwm_dac.md
# dds_pwm_dac

Downstream stage of the DDS datapath. It accepts signed two's-complement sine samples over a valid/ready handshake, double-buffers them, and converts each one into a single-bit PWM frame of 2^DATA_W clocks for an external RC-filtered DAC pin. It reports frame boundaries and sample underruns, and drains cleanly when disabled.

## Interface
- DATA_W, default 8: sample width; the PWM frame length is 2^DATA_W clocks.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; a low level requests a drain to idle.
- s_valid  in  1  upstream sample valid.
- s_data  in  DATA_W  signed two's-complement sample.
- s_ready  out  1  shadow register empty; a sample is accepted on a clk edge with s_valid & s_ready.
- pwm_out  out  1  PWM bit stream.
- frame_start  out  1  high in the first cycle of each running frame.
- underrun  out  1  one-cycle pulse when a frame starts without a fresh sample.
- underrun_count  out  8  saturating count of underruns.

## Operation
- Conversion: duty = s_data XOR MSB mask (offset binary). For DATA_W=8: -128→0, 0→128, 127→255.
- Registers:
  - shadow, with shadow_full flag.
  - active duty.
  - cnt, DATA_W bits.
  - FSM state: IDLE, RUN, DRAIN.
- s_ready = ~shadow_full in every state, including IDLE.
- IDLE:
  - cnt is held at 0 and pwm_out = 0.
  - When en & shadow_full, on the next edge: state ← RUN, active ← shadow, shadow_full ← 0, cnt = 0.
- RUN:
  - cnt increments every cycle and wraps from 2^DATA_W−1 to 0.
  - At the wrap edge, if shadow_full: active ← shadow and shadow_full ← 0.
  - Otherwise active holds its previous value, the underrun pulse is asserted and underrun_count increments, saturating at 255.
  - en low → DRAIN on the next edge; cnt keeps counting.
- DRAIN:
  - Counting and PWM continue.
  - At the wrap edge → IDLE. No load and no underrun.
  - en high again while in DRAIN → RUN with no frame disturbance.
- pwm_out = (state ≠ IDLE) & (cnt < active), decoded from registered state only.
- frame_start = (state ≠ IDLE) & (cnt == 0).
- An accept and a wrap load at the same edge cannot collide: s_ready is low whenever shadow is full. An accept at a wrap edge with shadow empty fills shadow and still counts as an underrun for that frame.

## Timing
- Reset values:
  - state IDLE, cnt 0, shadow_full 0, shadow 0.
  - active = mid-scale (2^(DATA_W−1)).
  - pwm_out 0, frame_start 0, underrun 0, underrun_count 0.
  - s_ready 1.
- Start latency: a sample accepted at edge k in IDLE with en=1 gives RUN at edge k+1. frame_start and the first pwm_out high both occur in cycle k+1.
- In steady state a sample accepted during frame N is output in frame N+1. The maximum sustained input rate is one sample per 2^DATA_W clocks.
- A high duty d gives exactly d high cycles at the start of each frame, then 2^DATA_W−d low cycles.
- underrun is asserted in the same cycle as frame_start.
- rst asserted mid-frame: all registers take their reset values at that edge, and any shadow sample is discarded.

## Structure
- Package dds_pkg holds:
  - the state enum (IDLE/RUN/DRAIN);
  - the MID_SCALE constant;
  - the UNDERRUN_MAX (255) constant.
- Sub-module pwm_frame_counter holds cnt and produces wrap and frame-zero strobes, with inputs clk, rst, run.
- The top module holds the FSM, the shadow/active registers and the counters.

## Test plan
- Reset → all outputs take their reset values and s_ready=1. With en=0, holding a sample in shadow keeps IDLE and pwm_out=0.
- en=1, single sample 0x00 → frame_start in the next cycle, pwm_out high for 128 cycles then low for 128. underrun is asserted at the second frame_start.
- Back-to-back samples 0x80, 0x7F, 0x40 with s_valid held → duties 0, 255, 192 in consecutive frames. s_ready drops each time shadow fills and rises at the wrap edge.
- Feed 0x20, then starve → duty 160 repeats. underrun pulses once per frame; underrun_count reaches 255 and holds there after 300 starved frames.
- Drop en at cnt=100 → the frame completes, IDLE at the wrap, pwm_out=0, no underrun. In a repeat, re-raising en at cnt=200 continues RUN with an unbroken frame.
- Assert rst at cnt=50 with shadow full → the next cycle shows reset values, and the shadow sample never appears on pwm_out.
